// File: rtl/ls_mem_sequencer.sv
// ls_mem_sequencer
// Load/store memory access sequencer. Takes a size code, an effective address
// and store data from the load/store size encoder. It runs one bus cycle, or two
// for a doubleword, on the data-memory port using the mem_moc handshake. It then
// returns lane-aligned, sign/zero-extended load data and a done/fault pulse.
//
// Optional build macro: ALIGN_CHECK_EN
//   defined   - a misaligned halfword/word/doubleword faults without a bus cycle
//   undefined - low address bits outside the lane rules are simply ignored
module ls_mem_sequencer #(
  parameter int unsigned TIMEOUT   = 16, // max wait cycles per bus cycle, 0 = never
  parameter int unsigned DW_STRIDE = 4   // address step to the second doubleword word
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  size,
  input  logic        ld,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] wdata_hi,
  output logic        mem_req,
  output logic        mem_rw,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_moc,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic [31:0] rdata_hi,
  output logic        fault
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC1 = 2'd1;
  localparam logic [1:0] S_ACC2 = 2'd2;
  localparam logic [1:0] S_FIN  = 2'd3;

  // size[1:0] selects the width; size[2] selects sign extension.
  localparam logic [1:0] SZ_BYTE  = 2'd0;
  localparam logic [1:0] SZ_HALF  = 2'd1;
  localparam logic [1:0] SZ_WORD  = 2'd2;
  localparam logic [1:0] SZ_DWORD = 2'd3;

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic [1:0]    state_q, state_d;
  logic [2:0]    size_q, size_d;
  logic          ld_q, ld_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   wdata_hi_q, wdata_hi_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          fault_q, fault_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [31:0]   rdata_hi_q, rdata_hi_d;

  logic          illegal_start;
  logic          misaligned_start;
  logic          timeout_hit;
  logic [31:0]   word_addr;
  logic [7:0]    byte_lane;
  logic [15:0]   half_lane;
  logic [31:0]   load_ext;

  // Codes 110 and 111 are the only illegal sizes.
  assign illegal_start = size[2] & size[1];

`ifdef ALIGN_CHECK_EN
  // Flag accesses whose low address bits break the natural alignment of the size.
  always_comb begin
    misaligned_start = 1'b0;
    case (size[1:0])
      SZ_HALF:           misaligned_start = addr[0];
      SZ_WORD, SZ_DWORD: misaligned_start = |addr[1:0];
      default:           misaligned_start = 1'b0;
    endcase
  end
`else
  assign misaligned_start = 1'b0;
`endif

  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1));
  assign word_addr   = {addr_q[31:2], 2'b00};

  // Select the addressed byte/halfword lane and extend it to 32 bits.
  always_comb begin
    case (addr_q[1:0])
      2'd0:    byte_lane = mem_rdata[7:0];
      2'd1:    byte_lane = mem_rdata[15:8];
      2'd2:    byte_lane = mem_rdata[23:16];
      default: byte_lane = mem_rdata[31:24];
    endcase
    half_lane = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (size_q[1:0])
      SZ_BYTE: load_ext = size_q[2] ? {{24{byte_lane[7]}}, byte_lane}
                                    : {24'h0, byte_lane};
      SZ_HALF: load_ext = size_q[2] ? {{16{half_lane[15]}}, half_lane}
                                    : {16'h0, half_lane};
      default: load_ext = mem_rdata;
    endcase
  end

  // Bus outputs: driven only during ACC1/ACC2, all-zero otherwise.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    mem_req   = 1'b0;
    mem_rw    = 1'b0;
    mem_addr  = 32'h0;
    mem_be    = 4'h0;
    mem_wdata = 32'h0;
    case (state_q)
      S_ACC1: begin
        mem_req  = 1'b1;
        mem_rw   = ld_q;
        mem_addr = word_addr;
        case (size_q[1:0])
          SZ_BYTE: begin
            mem_be    = 4'b0001 << addr_q[1:0];
            mem_wdata = {4{wdata_q[7:0]}};
          end
          SZ_HALF: begin
            mem_be    = addr_q[1] ? 4'b1100 : 4'b0011;
            mem_wdata = {2{wdata_q[15:0]}};
          end
          default: begin
            mem_be    = 4'b1111;
            mem_wdata = wdata_q;
          end
        endcase
      end
      S_ACC2: begin
        mem_req   = 1'b1;
        mem_rw    = ld_q;
        mem_addr  = word_addr + 32'(DW_STRIDE);
        mem_be    = 4'b1111;
        mem_wdata = wdata_hi_q;
      end
      default: ;
    endcase
  end

  // Next-state logic: request latching, handshake, timeout and load capture.
  always_comb begin
    state_d    = state_q;
    size_d     = size_q;
    ld_d       = ld_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wdata_hi_d = wdata_hi_q;
    cnt_d      = cnt_q;
    fault_d    = 1'b0;
    rdata_d    = rdata_q;
    rdata_hi_d = rdata_hi_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          size_d     = size;
          ld_d       = ld;
          addr_d     = addr;
          wdata_d    = wdata;
          wdata_hi_d = wdata_hi;
          cnt_d      = '0;
          if (illegal_start || misaligned_start) begin
            state_d = S_FIN;
            fault_d = 1'b1;
          end else begin
            state_d = S_ACC1;
          end
        end
      end
      S_ACC1: begin
        // A completion on the last allowed cycle still wins over the timeout.
        if (mem_moc) begin
          if (ld_q) rdata_d = load_ext;
          cnt_d   = '0;
          state_d = (size_q[1:0] == SZ_DWORD) ? S_ACC2 : S_FIN;
        end else if (timeout_hit) begin
          state_d = S_FIN;
          fault_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_ACC2: begin
        if (mem_moc) begin
          if (ld_q) rdata_hi_d = mem_rdata;
          state_d = S_FIN;
        end else if (timeout_hit) begin
          state_d = S_FIN;
          fault_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any bus cycle at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      size_q     <= 3'h0;
      ld_q       <= 1'b0;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      wdata_hi_q <= 32'h0;
      cnt_q      <= '0;
      fault_q    <= 1'b0;
      rdata_q    <= 32'h0;
      rdata_hi_q <= 32'h0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state_q    <= state_d;
      size_q     <= size_d;
      ld_q       <= ld_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wdata_hi_q <= wdata_hi_d;
      cnt_q      <= cnt_d;
      fault_q    <= fault_d;
      rdata_q    <= rdata_d;
      rdata_hi_q <= rdata_hi_d;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_FIN);
  assign fault    = fault_q;
  assign rdata    = rdata_q;
  assign rdata_hi = rdata_hi_q;

endmodule

// File: tb/tb_ls_mem_sequencer.sv
// tb_ls_mem_sequencer
// Directed bench for ls_mem_sequencer (TIMEOUT = 16, DW_STRIDE = 4).
// Inputs change 1 time unit after a rising edge, and outputs are sampled there too.
// The ALIGN_CHECK_EN build is covered by the misaligned word load step.
module tb_ls_mem_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  size;
  logic        ld;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] wdata_hi;
  logic        mem_req;
  logic        mem_rw;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_moc;
  logic        busy;
  logic        done;
  logic [31:0] rdata;
  logic [31:0] rdata_hi;
  logic        fault;

  int checks = 0;
  int errors = 0;

  ls_mem_sequencer #(.TIMEOUT(16), .DW_STRIDE(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .size      (size),
    .ld        (ld),
    .addr      (addr),
    .wdata     (wdata),
    .wdata_hi  (wdata_hi),
    .mem_req   (mem_req),
    .mem_rw    (mem_rw),
    .mem_addr  (mem_addr),
    .mem_be    (mem_be),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_moc   (mem_moc),
    .busy      (busy),
    .done      (done),
    .rdata     (rdata),
    .rdata_hi  (rdata_hi),
    .fault     (fault)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic [2:0] s, input logic l, input logic [31:0] a,
                     input logic [31:0] wd, input logic [31:0] wh);
    start    = 1'b1;
    size     = s;
    ld       = l;
    addr     = a;
    wdata    = wd;
    wdata_hi = wh;
  endtask

  initial begin
    int n;
    rst_n = 1'b0; start = 1'b0; size = 3'd0; ld = 1'b0; addr = 32'h0;
    wdata = 32'h0; wdata_hi = 32'h0; mem_rdata = 32'h0; mem_moc = 1'b0;

    // Reset state
    #12;
    check("rst_mem_req", mem_req, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_fault", fault, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_rdata", rdata, 0);
    check("rst_rdata_hi", rdata_hi, 0);
    @(negedge clk); rst_n = 1'b1;
    tick();

    // Signed byte load at 0x1003, zero-wait completion
    req(3'b100, 1'b1, 32'h1003, 32'h0, 32'h0);
    tick();
    start = 1'b0; addr = 32'hDEAD_BEEF; size = 3'b000;  // request inputs must be latched
    mem_moc = 1'b1; mem_rdata = 32'h80FF_0000;
    check("sb_mem_req", mem_req, 1);
    check("sb_mem_rw", mem_rw, 1);
    check("sb_mem_be", mem_be, 4'b1000);
    check("sb_mem_addr", mem_addr, 32'h1000);
    check("sb_done_early", done, 0);
    tick();
    mem_moc = 1'b0;
    check("sb_done", done, 1);
    check("sb_fault", fault, 0);
    check("sb_mem_req_off", mem_req, 0);
    check("sb_rdata", rdata, 32'hFFFF_FF80);
    tick();
    check("sb_done_pulse", done, 0);
    check("sb_busy_off", busy, 0);

    // Unsigned halfword store at 0x2002; start during FIN is ignored
    req(3'b001, 1'b0, 32'h2002, 32'h1234_ABCD, 32'h0);
    tick();
    start = 1'b0;
    check("hs_mem_be", mem_be, 4'b1100);
    check("hs_mem_wdata", mem_wdata, 32'hABCD_ABCD);
    check("hs_mem_rw", mem_rw, 0);
    check("hs_mem_addr", mem_addr, 32'h2000);
    mem_moc = 1'b1;
    tick();
    mem_moc = 1'b0;
    check("hs_done", done, 1);
    check("hs_rdata_kept", rdata, 32'hFFFF_FF80);
    req(3'b010, 1'b1, 32'h0, 32'h0, 32'h0);
    tick();
    check("fin_start_ignored", busy, 0);
    start = 1'b0;

    // Doubleword load at 0x3000, two wait cycles on each beat
    req(3'b011, 1'b1, 32'h3000, 32'h0, 32'h0);
    tick();
    start = 1'b0;
    check("dl_addr1", mem_addr, 32'h3000);
    check("dl_be1", mem_be, 4'b1111);
    tick(); tick();
    mem_moc = 1'b1; mem_rdata = 32'h1111_1111;
    tick();
    mem_moc = 1'b0;
    check("dl_no_done_mid", done, 0);
    check("dl_req2", mem_req, 1);
    check("dl_addr2", mem_addr, 32'h3004);
    check("dl_be2", mem_be, 4'b1111);
    tick(); tick();
    check("dl_wait_done", done, 0);
    mem_moc = 1'b1; mem_rdata = 32'h2222_2222;
    tick();
    mem_moc = 1'b0;
    check("dl_done", done, 1);
    check("dl_rdata", rdata, 32'h1111_1111);
    check("dl_rdata_hi", rdata_hi, 32'h2222_2222);
    tick();

    // Doubleword store at 0x4008
    req(3'b011, 1'b0, 32'h4008, 32'hAAAA_0001, 32'hBBBB_0002);
    tick();
    start = 1'b0; mem_moc = 1'b1;
    check("ds_wdata1", mem_wdata, 32'hAAAA_0001);
    tick();
    check("ds_addr2", mem_addr, 32'h400C);
    check("ds_wdata2", mem_wdata, 32'hBBBB_0002);
    tick();
    mem_moc = 1'b0;
    check("ds_done", done, 1);
    check("ds_rdata_hi_kept", rdata_hi, 32'h2222_2222);
    tick();

    // Unsigned byte load from lane 1
    req(3'b000, 1'b1, 32'h5001, 32'h0, 32'h0);
    tick();
    start = 1'b0; mem_moc = 1'b1; mem_rdata = 32'h0000_9A00;
    check("ub_mem_be", mem_be, 4'b0010);
    tick();
    mem_moc = 1'b0;
    check("ub_rdata", rdata, 32'h0000_009A);
    tick();

    // Signed halfword load from the upper lane
    req(3'b101, 1'b1, 32'h6002, 32'h0, 32'h0);
    tick();
    start = 1'b0; mem_moc = 1'b1; mem_rdata = 32'h8001_0000;
    check("sh_mem_be", mem_be, 4'b1100);
    tick();
    mem_moc = 1'b0;
    check("sh_rdata", rdata, 32'hFFFF_8001);
    tick();

    // Byte store replicated on all lanes
    req(3'b000, 1'b0, 32'h7002, 32'h0000_0055, 32'h0);
    tick();
    start = 1'b0; mem_moc = 1'b1;
    check("bs_mem_be", mem_be, 4'b0100);
    check("bs_mem_wdata", mem_wdata, 32'h5555_5555);
    tick();
    mem_moc = 1'b0;
    tick();

    // Timeout: word load with no completion
    req(3'b010, 1'b1, 32'h8000, 32'h0, 32'h0);
    tick();
    start = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check("to_cycles", 32'(n), 32'd16);
    check("to_fault", fault, 1);
    check("to_done", done, 1);
    check("to_mem_req", mem_req, 0);
    check("to_rdata_kept", rdata, 32'hFFFF_8001);
    tick();
    check("to_busy_off", busy, 0);
    check("to_fault_pulse", fault, 0);

    // Completion on the last allowed cycle beats the timeout
    req(3'b010, 1'b1, 32'h8100, 32'h0, 32'h0);
    tick();
    start = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    check("late_still_busy", mem_req, 1);
    mem_moc = 1'b1; mem_rdata = 32'hCAFE_F00D;
    tick();
    mem_moc = 1'b0;
    check("late_done", done, 1);
    check("late_fault", fault, 0);
    check("late_rdata", rdata, 32'hCAFE_F00D);
    tick();

    // Reset during ACC2 abandons the access at once
    req(3'b011, 1'b1, 32'h9000, 32'h0, 32'h0);
    tick();
    start = 1'b0; mem_moc = 1'b1; mem_rdata = 32'h0101_0101;
    tick();
    mem_moc = 1'b0;
    check("mr_in_acc2", mem_addr, 32'h9004);
    rst_n = 1'b0;
    #1;
    check("mr_mem_req", mem_req, 0);
    check("mr_busy", busy, 0);
    check("mr_done", done, 0);
    check("mr_rdata", rdata, 0);
    @(negedge clk); rst_n = 1'b1;
    tick();
    check("mr_no_done", done, 0);
    req(3'b010, 1'b1, 32'hA000, 32'h0, 32'h0);
    tick();
    start = 1'b0; mem_moc = 1'b1; mem_rdata = 32'h1357_9BDF;
    check("mr_restart_req", mem_req, 1);
    tick();
    mem_moc = 1'b0;
    check("mr_restart_done", done, 1);
    check("mr_restart_rdata", rdata, 32'h1357_9BDF);
    tick();

    // Illegal size 111: no bus cycle, fault one cycle after start
    req(3'b111, 1'b1, 32'hB000, 32'h0, 32'h0);
    tick();
    start = 1'b0;
    check("il_mem_req", mem_req, 0);
    check("il_done", done, 1);
    check("il_fault", fault, 1);
    check("il_rdata_kept", rdata, 32'h1357_9BDF);
    tick();
    check("il_busy_off", busy, 0);

    // Misaligned word load at 0x0002
    req(3'b010, 1'b1, 32'h0000_0002, 32'h0, 32'h0);
    tick();
    start = 1'b0;
`ifdef ALIGN_CHECK_EN
    check("al_mem_req", mem_req, 0);
    check("al_done", done, 1);
    check("al_fault", fault, 1);
    tick();
`else
    check("al_mem_req", mem_req, 1);
    check("al_mem_addr", mem_addr, 32'h0);
    check("al_mem_be", mem_be, 4'b1111);
    mem_moc = 1'b1; mem_rdata = 32'h2468_ACE0;
    tick();
    mem_moc = 1'b0;
    check("al_done", done, 1);
    check("al_fault", fault, 0);
    check("al_rdata", rdata, 32'h2468_ACE0);
    tick();
`endif
    check("al_busy_off", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
